gpio_pixel_packer: RTL

GPIO_PIXEL_PACKER -- requirements
Module: gpio_pixel_packer

---
 rtl/gpio_pixel_packer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gpio_pixel_packer.sv
// Packs planar R/G/B GPIO words (four pixels per word) into a 24-bit pixel
// stream with frame framing, back-pressure and a sticky channel overrun flag.
module gpio_pixel_packer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      gpio,
  input  logic             gpio_en_r,
  input  logic             gpio_en_g,
  input  logic             gpio_en_b,
  input  logic             gpio_en,
  output logic [23:0]      pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_last,
  output logic             frame_done,
  output logic [CNT_W-1:0] pix_count,
  output logic             overrun
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;
  state_t state_q, state_d;

  logic [31:0] r_reg, g_reg, b_reg;
  logic        r_full, g_full, b_full, cap_eof;
  logic [31:0] grp_r, grp_g, grp_b;
  logic [1:0]  lane;
  logic        emit_eof;

  logic        busy, hs, rel, complete, xfer, cap_any;
  logic        eof_cap, eof_emit, eof_idle;
  logic [31:0] r_nxt, g_nxt, b_nxt;

  always_comb begin
    busy     = (state_q == S_EMIT);
    hs       = busy && pix_ready;
    rel      = hs && (lane == 2'd3);
    r_nxt    = (gpio_en_r && !r_full) ? gpio : r_reg;
    g_nxt    = (gpio_en_g && !g_full) ? gpio : g_reg;
    b_nxt    = (gpio_en_b && !b_full) ? gpio : b_reg;
    complete = (r_full || gpio_en_r) && (g_full || gpio_en_g) && (b_full || gpio_en_b);
    xfer     = complete && (!busy || rel);
    // End-of-frame attaches to whichever stage will hold the frame's last pixel.
    cap_any  = r_full || g_full || b_full || gpio_en_r || gpio_en_g || gpio_en_b;
    eof_cap  = gpio_en && cap_any;
    eof_emit = gpio_en && !cap_any && busy && !rel;
    eof_idle = gpio_en && !cap_any && (!busy || rel);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (xfer) state_d = S_EMIT;
      S_EMIT: if (rel && !xfer) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pix_valid = busy;
    pix_data  = {grp_r[{lane, 3'b000} +: 8], grp_g[{lane, 3'b000} +: 8],
                 grp_b[{lane, 3'b000} +: 8]};
    pix_last  = busy && (lane == 2'd3) && emit_eof;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_reg      <= '0;
      g_reg      <= '0;
      b_reg      <= '0;
      r_full     <= 1'b0;
      g_full     <= 1'b0;
      b_full     <= 1'b0;
      cap_eof    <= 1'b0;
      grp_r      <= '0;
      grp_g      <= '0;
      grp_b      <= '0;
      lane       <= '0;
      emit_eof   <= 1'b0;
      frame_done <= 1'b0;
      pix_count  <= '0;
      overrun    <= 1'b0;
    end else begin
      if ((gpio_en_r && r_full) || (gpio_en_g && g_full) || (gpio_en_b && b_full))
        overrun <= 1'b1;
      if (xfer) begin
        r_full   <= 1'b0;
        g_full   <= 1'b0;
        b_full   <= 1'b0;
        cap_eof  <= 1'b0;
        grp_r    <= r_nxt;
        grp_g    <= g_nxt;
        grp_b    <= b_nxt;
        emit_eof <= cap_eof || eof_cap;
        lane     <= '0;
      end else begin
        r_full  <= r_full || gpio_en_r;
        g_full  <= g_full || gpio_en_g;
        b_full  <= b_full || gpio_en_b;
        r_reg   <= r_nxt;
        g_reg   <= g_nxt;
        b_reg   <= b_nxt;
        cap_eof <= cap_eof || eof_cap;
        if (hs) lane <= lane + 2'd1;
        if (rel) emit_eof <= 1'b0;
        else if (eof_emit) emit_eof <= 1'b1;
      end
      frame_done <= (hs && pix_last) || eof_idle;
      pix_count  <= (hs && pix_last) ? '0 : pix_count + CNT_W'(hs);
    end
  end

endmodule
